// File: rtl/bs_add_const_pkg.sv
// Shared definitions for the bit-serial blocks of the modmul_bs datapath:
// the frame FSM state encoding, the serial add/sub mode values and a small
// full-adder helper.
package bs_pkg;

    typedef logic [1:0] state_t;

    // Frame FSM states
    localparam state_t ST_IDLE = 2'd0;  // no frame seen since reset
    localparam state_t ST_RUN  = 2'd1;  // inside a word, bits 0..WIDTH-1
    localparam state_t ST_TAIL = 2'd2;  // past bit WIDTH-1, sign-extended stream

    // Serial add/sub mode values carried on the 'sub' input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Carry out of a 1-bit full adder
    function automatic logic fa_carry(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/bs_add_const_if.sv
// Serial operand / result bundle of bs_add_const.
// Inputs a, isync, kval and sub are sampled on every rising clock edge and
// carry no backpressure; kval/sub matter only in a cycle where isync=1.
// All result signals (q, osync, ocarry, odone, ovf) are registered and
// describe the input bit presented one cycle earlier. dbg_state exposes the
// frame FSM.
interface bs_add_const_if #(
    parameter int WIDTH = 16
);
    import bs_pkg::*;

    logic             a;
    logic             isync;
    logic [WIDTH-1:0] kval;
    logic             sub;
    logic             q;
    logic             osync;
    logic             ocarry;
    logic             odone;
    logic             ovf;
    state_t           dbg_state;

    modport master (
        output a, isync, kval, sub,
        input  q, osync, ocarry, odone, ovf, dbg_state
    );

    modport slave (
        input  a, isync, kval, sub,
        output q, osync, ocarry, odone, ovf, dbg_state
    );

endinterface

// File: rtl/bs_add_const_fa_cell.sv
// Registered 1-bit full adder. On a frame-start cycle the carry-in is forced
// to the subtract flag (the "+1" of a two's complement negate); otherwise it
// comes from the carry register. When disabled both registers clear.
module bs_fa_cell
    import bs_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_i,      // add this cycle; 0 forces q/carry to 0
    input  logic load_i,    // frame start: take carry-in from sub_i
    input  logic a_i,
    input  logic kb_i,
    input  logic sub_i,
    output logic q_o,
    output logic carry_o,
    output logic cin_o,     // carry into the current bit (combinational)
    output logic cout_o     // carry out of the current bit (combinational)
);

    logic q_q, q_d;
    logic carry_q, carry_d;

    assign cin_o  = load_i ? sub_i : carry_q;
    assign cout_o = fa_carry(a_i, kb_i, cin_o);

    // Next sum bit and carry, or zeros while no frame is active
    always_comb begin
        q_d     = 1'b0;
        carry_d = 1'b0;
        if (en_i) begin
            q_d     = a_i ^ kb_i ^ cin_o;
            carry_d = cout_o;
        end
    end

    // Sum and carry registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q     <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign q_o     = q_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/bs_add_const.sv
// Bit-serial, LSB-first adder/subtractor of a per-frame constant K.
// The constant (already complemented for subtraction) is held in a shift
// register that sign-fills, so streams longer than WIDTH keep producing the
// sign-extended sum. odone/ovf flag the result bit WIDTH-1 of each complete
// word; a new isync aborts any word in progress.
module bs_add_const
    import bs_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic reset,
    bs_add_const_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(WIDTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] kreg_q, kreg_d;
    logic [WIDTH-1:0] keff;
    logic             kb;
    logic             fa_en, last_bit;
    logic             fa_cin, fa_cout;
    logic             q_w, carry_w;
    logic             osync_q;
    logic             odone_q, odone_d;
    logic             ovf_q, ovf_d;

    // Constant as it enters the adder: complemented for subtraction
    assign keff = (bus.sub == MODE_SUB) ? ~bus.kval : bus.kval;
    assign kb   = bus.isync ? keff[0] : kreg_q[0];

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: isync always (re)starts a word
    always_comb begin
        state_d = state_q;
        if (bus.isync) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:  if (cnt_q == LAST_IDX) state_d = ST_TAIL;
                ST_TAIL: state_d = ST_TAIL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: adder enable and "MSB of the word processed now"
    always_comb begin
        fa_en    = bus.isync || (state_q != ST_IDLE);
        last_bit = !bus.isync && (state_q == ST_RUN) && (cnt_q == LAST_IDX);
    end

    // Bit counter and constant shifter next values
    always_comb begin
        cnt_d  = cnt_q;
        kreg_d = {kreg_q[WIDTH-1], kreg_q[WIDTH-1:1]};
        if (bus.isync) begin
            cnt_d  = CNT_W'(1);
            kreg_d = {keff[WIDTH-1], keff[WIDTH-1:1]};
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (state_q == ST_TAIL) begin
            cnt_d = SAT_CNT;
        end
        odone_d = last_bit;
        ovf_d   = last_bit & (fa_cin ^ fa_cout);
    end

    // Counter, constant shifter and frame flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            kreg_q  <= '0;
            osync_q <= 1'b0;
            odone_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            kreg_q  <= kreg_d;
            osync_q <= bus.isync;
            odone_q <= odone_d;
            ovf_q   <= ovf_d;
        end
    end

    bs_fa_cell u_fa (
        .clk     (clk),
        .reset   (reset),
        .en_i    (fa_en),
        .load_i  (bus.isync),
        .a_i     (bus.a),
        .kb_i    (kb),
        .sub_i   (bus.sub),
        .q_o     (q_w),
        .carry_o (carry_w),
        .cin_o   (fa_cin),
        .cout_o  (fa_cout)
    );

    assign bus.q         = q_w;
    assign bus.ocarry    = carry_w;
    assign bus.osync     = osync_q;
    assign bus.odone     = odone_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bs_add_const.sv
// Bench for bs_add_const with WIDTH=8: directed and random frames compared
// against an integer-arithmetic model of a +/- K.
module tb_bs_add_const;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] exp_q[$];

    bs_add_const_if #(.WIDTH(W)) bus ();

    bs_add_const #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one input bit, clock it in, return just after the edge
    task automatic drive(input logic ab, input logic sy, input logic [W-1:0] kv, input logic sb);
        bus.a     = ab;
        bus.isync = sy;
        bus.kval  = kv;
        bus.sub   = sb;
        @(posedge clk);
        #1;
    endtask

    // Reference: n-bit stream value A plus/minus sign-extended K, plus the
    // carry out and signed overflow of the WIDTH-bit word.
    function automatic void model(input longint unsigned aval, input int n,
                                  input logic [W-1:0] k, input logic s,
                                  output longint unsigned res, output logic cw, output logic ow);
        longint           kx;
        longint unsigned  mask;
        int unsigned      aw, kk, t;
        logic [W-1:0]     kn;
        int               sa, sk, tr;
        kx   = longint'($signed(k));
        mask = (64'd1 << n) - 64'd1;
        res  = (aval + longint'(s ? -kx : kx)) & mask;
        aw   = int'(aval & ((64'd1 << W) - 64'd1));
        kn   = ~k;
        kk   = s ? int'(kn) : int'(k);
        t    = aw + kk + (s ? 1 : 0);
        cw   = ((t >> W) & 1) != 0;
        sa   = (aw >= (1 << (W - 1))) ? int'(aw) - (1 << W) : int'(aw);
        sk   = int'($signed(k));
        tr   = s ? sa - sk : sa + sk;
        ow   = (tr > (1 << (W - 1)) - 1) || (tr < -(1 << (W - 1)));
    endfunction

    // Send n bits of a frame starting with isync and check every output bit
    task automatic send_frame(input string tag, input longint unsigned aval, input int n,
                              input logic [W-1:0] k, input logic s, output logic [63:0] got);
        longint unsigned res;
        logic cw, ow;
        logic [63:0] exp_word;
        model(aval, n, k, s, res, cw, ow);
        exp_q.push_back(res);
        got = '0;
        for (int i = 0; i < n; i++) begin
            drive(aval[i], (i == 0), k, s);
            got[i] = bus.q;
            check({tag, ".osync"}, 64'(bus.osync), 64'(i == 0));
            check({tag, ".odone"}, 64'(bus.odone), 64'(i == W - 1));
            check({tag, ".ovf"}, 64'(bus.ovf), 64'((i == W - 1) ? ow : 1'b0));
            if (i == W - 1 && n == W) check({tag, ".ocarry"}, 64'(bus.ocarry), 64'(cw));
        end
        exp_word = exp_q.pop_front();
        check({tag, ".q"}, got, exp_word);
    endtask

    initial begin
        logic [63:0] got;
        logic [W-1:0] k;
        bus.a = 1'b0; bus.isync = 1'b0; bus.kval = '0; bus.sub = 1'b0;

        // Reset state
        #2;
        check("rst.q", 64'(bus.q), 64'd0);
        check("rst.osync", 64'(bus.osync), 64'd0);
        check("rst.ocarry", 64'(bus.ocarry), 64'd0);
        check("rst.odone", 64'(bus.odone), 64'd0);
        check("rst.ovf", 64'(bus.ovf), 64'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;

        // No frame yet: outputs stay 0 whatever a does
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(1)), 1'b0, 8'hFF, 1'b0);
            check("idle.q", 64'(bus.q), 64'd0);
            check("idle.ocarry", 64'(bus.ocarry), 64'd0);
        end

        // Directed words with hand-derived results
        send_frame("legacy_m3", 64'h10, W, 8'hFD, 1'b0, got);
        check("legacy_m3.const", got, 64'h0D);
        send_frame("add_ovf", 64'h7F, W, 8'h01, 1'b0, got);
        check("add_ovf.const", got, 64'h80);
        send_frame("sub_ovf", 64'h80, W, 8'h01, 1'b1, got);
        check("sub_ovf.const", got, 64'h7F);
        send_frame("sub5_a3", 64'h03, W, 8'h05, 1'b1, got);
        check("sub5_a3.const", got, 64'hFE);
        send_frame("sub5_a5", 64'h05, W, 8'h05, 1'b1, got);
        check("sub5_a5.const", got, 64'h00);
        check("sub5_a5.ocarry_end", 64'(bus.ocarry), 64'd1);

        // Back-to-back frames, K alternating -3 / +7
        for (int f = 0; f < 8; f++)
            send_frame("b2b", 64'($urandom_range(255)), W, (f % 2 == 0) ? 8'hFD : 8'h07, 1'b0, got);

        // isync at bit 4 aborts the word, then a full word
        send_frame("abort4", 64'($urandom_range(255)), 4, 8'h2A, 1'b0, got);
        send_frame("after_abort4", 64'($urandom_range(255)), W, 8'h2A, 1'b1, got);
        // isync colliding with bit WIDTH-1 of the previous word
        send_frame("abort_msb", 64'($urandom_range(255)), W - 1, 8'h91, 1'b1, got);
        send_frame("after_abort_msb", 64'($urandom_range(255)), W, 8'h91, 1'b0, got);

        // Random constants, modes and operands
        for (int f = 0; f < 24; f++) begin
            k = W'($urandom_range(255));
            send_frame("rand", 64'($urandom_range(255)), W, k, 1'($urandom_range(1)), got);
        end

        // Asynchronous reset in the middle of a word
        send_frame("pre_rst", 64'hFF, 3, 8'h00, 1'b0, got);
        #2;
        reset = 1'b1;
        #1;
        check("arst.q", 64'(bus.q), 64'd0);
        check("arst.osync", 64'(bus.osync), 64'd0);
        check("arst.ocarry", 64'(bus.ocarry), 64'd0);
        check("arst.odone", 64'(bus.odone), 64'd0);
        check("arst.ovf", 64'(bus.ovf), 64'd0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'h55, 1'b0);
            check("post_rst.q", 64'(bus.q), 64'd0);
            check("post_rst.odone", 64'(bus.odone), 64'd0);
        end

        // 12-bit stream: bits 8..11 are the sign-extended sum
        send_frame("ext12_add", 64'($urandom_range(4095)), 12, 8'hF3, 1'b0, got);
        send_frame("ext12_sub", 64'($urandom_range(4095)), 12, 8'h6B, 1'b1, got);
        send_frame("ext12_neg", 64'h0F0, 12, 8'h80, 1'b1, got);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
